sha_core_arbiter: RTL and testbench
===================================

Name: sha_core_arbiter

Overview:
Shares one SHA-256 compression core (one PADDED_SIZE-bit block in, 256-bit digest out) between NUM_REQ requesters. Round-robin arbitration selects one requester, latches its padded block, and pulses the core start. It then waits for core done or a timeout and returns the digest with the winner's ID over a valid/ready response channel. It sits between the block producers (padders) and the single compression datapath.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
PADDED_SIZE, 512, width of one padded message block
TIMEOUT, 1024, max BUSY cycles before an error response; 0 disables the timeout
ID_W, $clog2(NUM_REQ), width of the requester index

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (sampled on clk rising edge, 0 = reset)
req_valid  in  NUM_REQ  per-requester request; held until its req_ready pulse
req_block  in  NUM_REQ*PADDED_SIZE  requester i block in bits [i*PADDED_SIZE +: PADDED_SIZE]
req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
core_block  out  PADDED_SIZE  latched block to the core, stable from START until IDLE
core_start  out  1  one-cycle start pulse to the core
core_done  in  1  core completion flag
core_hash  in  256  core digest, valid when core_done=1
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_id  out  ID_W  index of the requester served
resp_hash  out  256  digest (0 on error)
resp_error  out  1  1 = timeout, no digest
busy  out  1  1 in every state except IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; rr_ptr=0; timeout counter=0.
  - All outputs 0, including core_block, resp_hash and resp_id.
  - Reset mid-operation aborts any request. No response is produced, and a later core_done is ignored because the state is IDLE.
- Arbitration (IDLE only): the winner is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- IDLE -> START at edge t when any req_valid=1. At the same edge:
  - core_block <= winner's slice; resp_id <= winner.
  - rr_ptr <= (winner+1) mod NUM_REQ.
  - req_ready[winner] <= 1.
- START (cycle t+1):
  - req_ready[winner]=1 and core_start=1 for exactly this cycle.
  - core_done in this cycle is ignored as stale.
  - Next state BUSY; counter cleared.
- BUSY:
  - Counter increments each cycle.
  - If core_done=1: resp_hash <= core_hash, resp_error <= 0, go to RESP.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: resp_hash <= 0, resp_error <= 1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - resp_valid=1, with resp_id, resp_hash and resp_error held stable.
  - On a cycle with resp_ready=1, go to IDLE and clear resp_valid next cycle.
  - resp_ready already high on the first RESP cycle completes the handshake in that cycle.
  - New requests are not arbitrated until back in IDLE, so minimum spacing is 3 cycles plus core latency.
- Requests arriving while busy wait. A requester must keep req_valid high until its req_ready pulse; dropping it earlier is unsupported, but the controller does not hang.
- Minimum latency, accept to resp_valid: START (1) + core latency L in BUSY + 1, with resp_valid high L+2 cycles after IDLE sampled the request.
- A single requester continuously valid is served back-to-back. Round-robin must not starve any requester while all are valid.

Test Plan:
1. Reset with all req_valid=0 -> all outputs 0, busy=0; after rst=1 and 10 idle cycles still 0.
2. Single request, requester 2 with the "abc" padded block, and a core model returning ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad after L=64 cycles -> req_ready=4'b0100 for one cycle, one core_start pulse, core_block equals the block, resp_valid with resp_id=2 and that hash, resp_error=0.
3. All four req_valid held high, resp_ready=1 -> resp_id order 0,1,2,3,0; each requester gets exactly one req_ready pulse per grant.
4. Core never asserts done, TIMEOUT=16 -> resp_valid 16 cycles after BUSY entry, resp_error=1, resp_hash=0; next request is served normally.
5. Backpressure: resp_ready=0 for 20 cycles after resp_valid -> outputs stable, no new req_ready while waiting; resp_ready=1 -> IDLE the next cycle.
6. rst=0 asserted in BUSY, then core_done pulses after release -> no resp_valid, state IDLE, and the next grant starts from requester 0.

Source files
------------

// File: rtl/sha_core_arbiter_if.sv
// Bundle of request, core and response signals for the shared SHA-256 core arbiter.
// Handshakes: req_valid is held until the one-cycle req_ready pulse; resp_valid holds id/hash/error until resp_ready.
interface sha_core_arbiter_if #(
    parameter int NUM_REQ     = 4,
    parameter int PADDED_SIZE = 512,
    parameter int ID_W        = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*PADDED_SIZE-1:0] req_block;
    logic [NUM_REQ-1:0]             req_ready;
    logic [PADDED_SIZE-1:0]         core_block;
    logic                           core_start;
    logic                           core_done;
    logic [255:0]                   core_hash;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [ID_W-1:0]                resp_id;
    logic [255:0]                   resp_hash;
    logic                           resp_error;

    modport master (
        input  req_valid, req_block, core_done, core_hash, resp_ready,
        output req_ready, core_block, core_start, resp_valid, resp_id, resp_hash, resp_error
    );

    modport slave (
        output req_valid, req_block, core_done, core_hash, resp_ready,
        input  req_ready, core_block, core_start, resp_valid, resp_id, resp_hash, resp_error
    );
endinterface

// File: rtl/sha_core_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core between NUM_REQ block producers,
// with a BUSY-cycle timeout that turns a missing core_done into an error response.
module sha_core_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PADDED_SIZE = 512,
    parameter int TIMEOUT     = 1024,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    sha_core_arbiter_if.master  bus,
    output logic                busy,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int                 CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W:0]      NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
    logic [PADDED_SIZE-1:0] core_block_q, core_block_d;
    logic [ID_W-1:0]        resp_id_q, resp_id_d;
    logic [255:0]           resp_hash_q, resp_hash_d;
    logic                   resp_error_q, resp_error_d;

    // Rotating the doubled request vector by rr_ptr puts the highest-priority requester at bit 0.
    logic [2*NUM_REQ-1:0]   dbl;
    logic [NUM_REQ-1:0]     rot;
    logic [ID_W-1:0]        win_off;
    logic [ID_W:0]          win_sum;
    logic [ID_W-1:0]        win_id;
    logic [ID_W-1:0]        rr_next;
    logic [PADDED_SIZE-1:0] win_block;

    assign dbl     = {bus.req_valid, bus.req_valid};
    assign rot     = NUM_REQ'(dbl >> rr_ptr_q);
    assign win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    assign win_id  = (win_sum >= NUM_REQ_X) ? ID_W'(win_sum - NUM_REQ_X) : win_sum[ID_W-1:0];
    assign rr_next = (win_id == LAST_ID) ? '0 : win_id + ID_W'(1);

    always_comb begin
        win_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) win_off = ID_W'(k);
        end
    end

    always_comb begin
        win_block = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_id == ID_W'(k)) win_block = bus.req_block[k*PADDED_SIZE +: PADDED_SIZE];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            core_block_q <= '0;
            resp_id_q    <= '0;
            resp_hash_q  <= '0;
            resp_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            core_block_q <= core_block_d;
            resp_id_q    <= resp_id_d;
            resp_hash_q  <= resp_hash_d;
            resp_error_q <= resp_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        core_block_d = core_block_q;
        resp_id_d    = resp_id_q;
        resp_hash_d  = resp_hash_q;
        resp_error_d = resp_error_q;
        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    state_d      = START;
                    core_block_d = win_block;
                    resp_id_d    = win_id;
                    rr_ptr_d     = rr_next;
                    req_ready_d  = NUM_REQ'(1) << win_id;
                end
            end
            START: begin
                // core_done seen here belongs to an earlier job and is ignored.
                state_d = BUSY;
                cnt_d   = '0;
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.core_done) begin
                    resp_hash_d  = bus.core_hash;
                    resp_error_d = 1'b0;
                    state_d      = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    resp_hash_d  = '0;
                    resp_error_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.core_block = core_block_q;
    assign bus.core_start = (state_q == START);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_hash  = resp_hash_q;
    assign bus.resp_error = resp_error_q;
    assign busy           = (state_q != IDLE);
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Directed bench for sha_core_arbiter: a vector table of single grants plus hand-written
// sequences for backpressure, reset during BUSY, continuous round-robin and timeout.
module tb_sha_core_arbiter;

  localparam logic [511:0] ABC_BLK  = {24'h616263, 8'h80, 416'h0, 64'h18};
  localparam logic [255:0] ABC_HASH =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] H2_HASH  =
    256'h0f1e2d3c4b5a69788796a5b4c3d2e1f00112233445566778899aabbccddeeff0;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd2;

  typedef struct {
    logic [3:0] mask;
    int         lat;
    logic [1:0] exp_id;
    logic [3:0] exp_ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, busy_to;
  logic [1:0] st, st_to;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int ready_cnt [4] = '{0, 0, 0, 0};
  int core_lat = 1;
  int core_cnt = 0;

  logic [511:0] blk [4];
  vec_t vecs [7];
  logic [1:0] exp_q [$];

  sha_core_arbiter_if #(.NUM_REQ(4), .PADDED_SIZE(512)) bus ();
  sha_core_arbiter_if #(.NUM_REQ(4), .PADDED_SIZE(512)) bus_to ();

  sha_core_arbiter #(.NUM_REQ(4), .PADDED_SIZE(512), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .dbg_state_o(st)
  );

  sha_core_arbiter #(.NUM_REQ(4), .PADDED_SIZE(512), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .bus(bus_to), .busy(busy_to), .dbg_state_o(st_to)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- core model and pulse monitor ----------------
  function automatic logic [255:0] core_fn(input logic [511:0] b);
    if (b == ABC_BLK) return ABC_HASH;
    return b[511:256] ^ {b[127:0], b[255:128]};
  endfunction

  always @(posedge clk) begin
    if (bus.core_start) core_cnt <= core_lat;
    else if (core_cnt != 0) core_cnt <= core_cnt - 1;
  end

  assign bus.core_done = (core_cnt == 1);
  assign bus.core_hash = bus.core_done ? core_fn(bus.core_block) : '0;

  always @(negedge clk) begin
    if (bus.core_start) start_cnt <= start_cnt + 1;
    for (int i = 0; i < 4; i++) begin
      if (bus.req_ready[i]) ready_cnt[i] <= ready_cnt[i] + 1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_req_ready"}, 512'(bus.req_ready), 512'(0));
    chk({tag, "_core_block"}, bus.core_block, 512'(0));
    chk({tag, "_core_start"}, 512'(bus.core_start), 512'(0));
    chk({tag, "_resp_valid"}, 512'(bus.resp_valid), 512'(0));
    chk({tag, "_resp_id"}, 512'(bus.resp_id), 512'(0));
    chk({tag, "_resp_hash"}, 512'(bus.resp_hash), 512'(0));
    chk({tag, "_resp_error"}, 512'(bus.resp_error), 512'(0));
    chk({tag, "_busy"}, 512'(busy), 512'(0));
    chk({tag, "_state"}, 512'(st), 512'(S_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input int bound, output logic [3:0] got);
    got = '0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0) begin
        got = bus.req_ready;
        break;
      end
    end
  endtask

  task automatic wait_resp(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_txn(input string tag, input logic [3:0] mask, input int lat,
                        input logic [1:0] exp_id, input logic [3:0] exp_rdy);
    logic [3:0] got;
    logic       ok;
    int         s0, r0;
    s0 = start_cnt;
    r0 = ready_cnt[exp_id];
    core_lat = lat;
    bus.resp_ready = 1'b1;
    bus.req_valid = mask;
    wait_grant(40, got);
    chk({tag, "_grant"}, 512'(got), 512'(exp_rdy));
    chk({tag, "_core_block"}, bus.core_block, blk[exp_id]);
    bus.req_valid = '0;
    wait_resp(200, ok);
    chk({tag, "_resp_seen"}, 512'(ok), 512'(1));
    chk({tag, "_resp_id"}, 512'(bus.resp_id), 512'(exp_id));
    chk({tag, "_resp_hash"}, 512'(bus.resp_hash), 512'(core_fn(blk[exp_id])));
    chk({tag, "_resp_error"}, 512'(bus.resp_error), 512'(0));
    @(negedge clk);
    chk({tag, "_back_idle"}, 512'({bus.resp_valid, busy}), 512'(0));
    chk({tag, "_start_pulses"}, 512'(start_cnt - s0), 512'(1));
    chk({tag, "_ready_pulses"}, 512'(ready_cnt[exp_id] - r0), 512'(1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] got;
    logic       ok;
    logic       seen;
    int         k;
    int         r0 [4];
    logic [1:0] e;

    blk[0] = {16{32'h0123_4567}};
    blk[1] = {16{32'h89ab_cdef}};
    blk[2] = ABC_BLK;
    blk[3] = {16{32'hdead_beef}};
    bus.req_valid     = '0;
    bus.req_block     = {blk[3], blk[2], blk[1], blk[0]};
    bus.resp_ready    = 1'b1;
    bus_to.req_valid  = '0;
    bus_to.req_block  = {blk[3], blk[2], blk[1], blk[0]};
    bus_to.core_done  = 1'b0;
    bus_to.core_hash  = '0;
    bus_to.resp_ready = 1'b1;

    // rr_ptr starts at 0; each expected winner follows from the pointer left by the previous row.
    vecs[0] = '{mask: 4'b0100, lat: 64, exp_id: 2'd2, exp_ready: 4'b0100};
    vecs[1] = '{mask: 4'b0011, lat: 3,  exp_id: 2'd0, exp_ready: 4'b0001};
    vecs[2] = '{mask: 4'b0011, lat: 1,  exp_id: 2'd1, exp_ready: 4'b0010};
    vecs[3] = '{mask: 4'b1001, lat: 5,  exp_id: 2'd3, exp_ready: 4'b1000};
    vecs[4] = '{mask: 4'b1000, lat: 2,  exp_id: 2'd3, exp_ready: 4'b1000};
    vecs[5] = '{mask: 4'b1010, lat: 7,  exp_id: 2'd1, exp_ready: 4'b0010};
    vecs[6] = '{mask: 4'b0001, lat: 1,  exp_id: 2'd0, exp_ready: 4'b0001};

    // Reset state, then idle with no requests.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check_zero("idle10");

    // Table of single grants; row 0 is the "abc" block from requester 2.
    for (int i = 0; i < 7; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].mask, vecs[i].lat, vecs[i].exp_id, vecs[i].exp_ready);
    end

    // Backpressure: rr_ptr=1, so requester 2 wins; others wait while the response stalls.
    bus.resp_ready = 1'b0;
    core_lat = 4;
    bus.req_valid = 4'b0100;
    wait_grant(40, got);
    chk("bp_grant", 512'(got), 512'(4'b0100));
    bus.req_valid = 4'b1011;
    wait_resp(100, ok);
    chk("bp_resp_seen", 512'(ok), 512'(1));
    for (int i = 0; i < 20; i++) begin
      chk("bp_hold",
          512'({bus.resp_valid, bus.req_ready, bus.resp_id, bus.resp_error, bus.resp_hash}),
          512'({1'b1, 4'b0000, 2'd2, 1'b0, ABC_HASH}));
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 512'({st, bus.resp_valid}), 512'({S_IDLE, 1'b0}));
    wait_grant(40, got);
    chk("bp_next_grant", 512'(got), 512'(4'b1000));
    bus.req_valid = '0;
    wait_resp(100, ok);
    chk("bp_next_id", 512'({ok, bus.resp_id}), 512'({1'b1, 2'd3}));
    @(negedge clk);

    // Reset during BUSY: the late core_done must not produce a response.
    core_lat = 30;
    bus.req_valid = 4'b0100;
    wait_grant(40, got);
    chk("rb_grant", 512'(got), 512'(4'b0100));
    bus.req_valid = '0;
    repeat (5) @(negedge clk);
    chk("rb_in_busy", 512'(st), 512'(S_BUSY));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    chk("rb_no_resp", 512'(seen), 512'(0));
    check_zero("rb_after");
    do_txn("rb_rr_reset", 4'b1111, 2, 2'd0, 4'b0001);

    // All four requesters held valid from a fresh reset: grants follow 0,1,2,3,0.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) r0[i] = ready_cnt[i];
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    core_lat = 2;
    bus.resp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      e = exp_q.pop_front();
      wait_grant(40, got);
      chk($sformatf("rr_grant%0d", g), 512'(got), 512'(4'b0001 << e));
      if (g == 4) bus.req_valid = '0;
      wait_resp(100, ok);
      chk($sformatf("rr_resp%0d", g), 512'({ok, bus.resp_id}), 512'({1'b1, e}));
      chk($sformatf("rr_hash%0d", g), 512'(bus.resp_hash), 512'(core_fn(blk[e])));
    end
    repeat (3) @(negedge clk);
    chk("rr_pulses",
        512'({8'(ready_cnt[0] - r0[0]), 8'(ready_cnt[1] - r0[1]),
              8'(ready_cnt[2] - r0[2]), 8'(ready_cnt[3] - r0[3])}),
        512'({8'd2, 8'd1, 8'd1, 8'd1}));
    chk("rr_idle", 512'(busy), 512'(0));

    // Timeout instance (TIMEOUT=16): core never answers.
    bus_to.req_valid = 4'b0001;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_to.req_ready != 4'b0) begin
        got = bus_to.req_ready;
        break;
      end
    end
    chk("to_grant", 512'(got), 512'(4'b0001));
    bus_to.req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (st_to == S_BUSY) begin
        seen = 1'b1;
        break;
      end
    end
    chk("to_busy_seen", 512'(seen), 512'(1));
    k = 41;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus_to.resp_valid) begin
        k = i;
        break;
      end
    end
    chk("to_latency", 512'(k), 512'(16));
    chk("to_resp", 512'({bus_to.resp_error, bus_to.resp_id, bus_to.resp_hash}),
        512'({1'b1, 2'd0, 256'd0}));
    @(negedge clk);
    chk("to_back_idle", 512'({st_to, bus_to.resp_valid}), 512'({S_IDLE, 1'b0}));

    // Next request on the timeout instance; done already high during START is stale.
    bus_to.req_valid = 4'b0010;
    got = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_to.req_ready != 4'b0) begin
        got = bus_to.req_ready;
        break;
      end
    end
    chk("to2_grant", 512'(got), 512'(4'b0010));
    bus_to.req_valid = '0;
    bus_to.core_done = 1'b1;
    bus_to.core_hash = H2_HASH;
    @(negedge clk);
    chk("to2_stale_done", 512'(st_to), 512'(S_BUSY));
    @(negedge clk);
    chk("to2_resp", 512'({bus_to.resp_valid, bus_to.resp_error, bus_to.resp_id, bus_to.resp_hash}),
        512'({1'b1, 1'b0, 2'd1, H2_HASH}));
    bus_to.core_done = 1'b0;
    bus_to.core_hash = '0;
    @(negedge clk);
    chk("to2_back_idle", 512'(busy_to), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
